// File: rtl/payload_wr_arbiter_pkg.sv
// Shared types for the payload-store write arbiter: bus field types and arbiter FSM states.
package payload_wr_arbiter_pkg;

  typedef logic [31:0] data_t;
  typedef logic [7:0]  ttl_t;
  typedef logic [2:0]  byte_count_t;
  typedef logic [15:0] address_t;

  typedef enum logic [1:0] {StIdle, StBurst, StDrain, StDone} arb_state_e;

endpackage

// File: rtl/payload_wr_arbiter_rr_picker.sv
// Combinational round-robin select: first requester above last_grant, wrapping around.
module rr_picker #(
  parameter int unsigned  N_REQ = 4,
  localparam int unsigned REQ_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [REQ_W-1:0] last_grant,
  output logic [REQ_W-1:0] grant,
  output logic             any_req
);

  logic [REQ_W-1:0] cand;

  // Walk from the farthest offset down so the nearest requester is the last assignment.
  always_comb begin
    grant   = '0;
    cand    = '0;
    any_req = |req;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      cand = REQ_W'((int'(last_grant) + k) % int'(N_REQ));
      if (req[cand]) grant = cand;
    end
  end

endmodule

// File: rtl/payload_wr_arbiter.sv
// Packet-atomic round-robin arbiter for the payload-store write port, with length truncation.
module payload_wr_arbiter
  import payload_wr_arbiter_pkg::*;
#(
  parameter int unsigned  N_REQ     = 4,
  parameter int unsigned  MAX_WORDS = 256,
  localparam int unsigned REQ_W     = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req_valid,
  output logic [N_REQ-1:0]  req_ready,
  input  logic [N_REQ-1:0]  req_is_last,
  input  data_t             req_data       [N_REQ],
  input  ttl_t              req_ttl        [N_REQ],
  input  byte_count_t       req_byte_count [N_REQ],
  output logic [N_REQ-1:0]  done_valid,
  output address_t          done_address,
  output logic              done_trunc,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic              wr_is_last,
  output data_t             wr_data,
  output ttl_t              wr_ttl,
  output byte_count_t       wr_byte_count,
  input  address_t          wr_address
);

  localparam int unsigned WcW = $clog2(MAX_WORDS + 1);
  typedef logic [WcW-1:0] word_count_t;
  localparam word_count_t WcLast = word_count_t'(MAX_WORDS - 1);
  localparam word_count_t WcMax  = word_count_t'(MAX_WORDS);

  arb_state_e       state_q;
  logic [REQ_W-1:0] g_q;
  logic [REQ_W-1:0] last_grant_q;
  word_count_t      word_count_q;
  ttl_t             ttl_q;

  logic [REQ_W-1:0] pick;
  logic             any_req;
  logic [N_REQ-1:0] grant_oh;
  logic             xfer;

  rr_picker #(
    .N_REQ(N_REQ)
  ) u_rr_picker (
    .req       (req_valid),
    .last_grant(last_grant_q),
    .grant     (pick),
    .any_req   (any_req)
  );

  always_comb begin
    grant_oh      = '0;
    grant_oh[g_q] = 1'b1;
    wr_valid      = 1'b0;
    wr_is_last    = 1'b0;
    wr_data       = '0;
    wr_ttl        = '0;
    wr_byte_count = '0;
    req_ready     = '0;
    if (state_q == StBurst) begin
      wr_valid      = req_valid[g_q];
      // The word that reaches the length limit closes the packet on the store side.
      wr_is_last    = req_is_last[g_q] || (word_count_q == WcLast);
      wr_data       = req_data[g_q];
      wr_ttl        = (word_count_q == '0) ? req_ttl[g_q] : ttl_q;
      wr_byte_count = req_byte_count[g_q];
      if (wr_ready) req_ready = grant_oh;
    end else if (state_q == StDrain) begin
      req_ready = grant_oh;
    end
  end

  assign xfer = wr_valid && wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      g_q          <= '0;
      last_grant_q <= REQ_W'(N_REQ - 1);
      word_count_q <= '0;
      ttl_q        <= '0;
      done_valid   <= '0;
      done_address <= '0;
      done_trunc   <= 1'b0;
    end else begin
      done_valid <= '0;
      case (state_q)
        StIdle: begin
          if (any_req) begin
            g_q          <= pick;
            word_count_q <= '0;
            state_q      <= StBurst;
          end
        end
        StBurst: begin
          if (xfer) begin
            if (word_count_q == '0) ttl_q <= req_ttl[g_q];
            if (word_count_q != WcMax) word_count_q <= word_count_q + word_count_t'(1);
            if (req_is_last[g_q] || (word_count_q == WcLast)) begin
              done_address <= wr_address;
              done_trunc   <= !req_is_last[g_q];
              if (req_is_last[g_q]) begin
                done_valid <= grant_oh;
                state_q    <= StDone;
              end else begin
                state_q <= StDrain;
              end
            end
          end
        end
        StDrain: begin
          if (req_valid[g_q] && req_is_last[g_q]) begin
            done_valid <= grant_oh;
            state_q    <= StDone;
          end
        end
        StDone: begin
          last_grant_q <= g_q;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_payload_wr_arbiter.sv
// Directed bench for payload_wr_arbiter: per-cycle vector table plus stall/TTL/truncation/reset runs.
module tb_payload_wr_arbiter;
  import payload_wr_arbiter_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned MW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req_valid, req_ready, req_is_last, done_valid;
  data_t         req_data       [NR];
  ttl_t          req_ttl        [NR];
  byte_count_t   req_byte_count [NR];
  address_t      done_address, wr_address;
  logic          done_trunc, wr_valid, wr_ready, wr_is_last;
  data_t         wr_data;
  ttl_t          wr_ttl;
  byte_count_t   wr_byte_count;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  payload_wr_arbiter #(
    .N_REQ    (NR),
    .MAX_WORDS(MW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_is_last   (req_is_last),
    .req_data      (req_data),
    .req_ttl       (req_ttl),
    .req_byte_count(req_byte_count),
    .done_valid    (done_valid),
    .done_address  (done_address),
    .done_trunc    (done_trunc),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_is_last    (wr_is_last),
    .wr_data       (wr_data),
    .wr_ttl        (wr_ttl),
    .wr_byte_count (wr_byte_count),
    .wr_address    (wr_address)
  );

  typedef struct {
    logic [NR-1:0] valid;
    logic [NR-1:0] last;
    logic          ready;
    address_t      addr;
    logic          exp_wv;
    logic [NR-1:0] exp_rr;
    logic          exp_il;
    logic [NR-1:0] exp_dv;
    logic          exp_dt;
    int            exp_src;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic [NR-1:0] v, logic [NR-1:0] l, logic r, address_t a,
                              logic wv, logic [NR-1:0] rr, logic il, logic [NR-1:0] dv,
                              logic dt, int src);
    vec_t e;
    e.valid = v; e.last = l; e.ready = r; e.addr = a;
    e.exp_wv = wv; e.exp_rr = rr; e.exp_il = il; e.exp_dv = dv; e.exp_dt = dt;
    e.exp_src = src;
    vecs.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drv(input logic [NR-1:0] v, input logic [NR-1:0] l, input logic r);
    req_valid   = v;
    req_is_last = l;
    wr_ready    = r;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wr_valid"}, 32'(wr_valid), 32'd0);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, ".done_valid"}, 32'(done_valid), 32'd0);
    chk({tag, ".done_address"}, 32'(done_address), 32'd0);
    chk({tag, ".done_trunc"}, 32'(done_trunc), 32'd0);
    chk({tag, ".wr_is_last"}, 32'(wr_is_last), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Req0 3-word packet, then 2-word contest between Req1/Req2, then rotation 3,0,1.
    add(4'b0001, 4'b0000, 1, 16'h0010, 0, 4'b0000, 0, 4'b0000, 0, 0);
    add(4'b0001, 4'b0000, 1, 16'h0020, 1, 4'b0001, 0, 4'b0000, 0, 0);
    add(4'b0001, 4'b0000, 1, 16'h0030, 1, 4'b0001, 0, 4'b0000, 0, 0);
    add(4'b0001, 4'b0001, 1, 16'h0040, 1, 4'b0001, 1, 4'b0000, 0, 0);
    add(4'b0000, 4'b0000, 1, 16'h0050, 0, 4'b0000, 0, 4'b0001, 0, 0);
    add(4'b0000, 4'b0000, 1, 16'h0060, 0, 4'b0000, 0, 4'b0000, 0, 0);
    add(4'b0110, 4'b0000, 1, 16'h0061, 0, 4'b0000, 0, 4'b0000, 0, 0);
    add(4'b0110, 4'b0000, 1, 16'h0062, 1, 4'b0010, 0, 4'b0000, 0, 1);
    add(4'b0110, 4'b0010, 1, 16'h0063, 1, 4'b0010, 1, 4'b0000, 0, 1);
    add(4'b0100, 4'b0000, 1, 16'h0064, 0, 4'b0000, 0, 4'b0010, 0, 0);
    add(4'b0100, 4'b0000, 1, 16'h0065, 0, 4'b0000, 0, 4'b0000, 0, 0);
    add(4'b0100, 4'b0000, 1, 16'h0066, 1, 4'b0100, 0, 4'b0000, 0, 2);
    add(4'b0100, 4'b0100, 1, 16'h0067, 1, 4'b0100, 1, 4'b0000, 0, 2);
    add(4'b0000, 4'b0000, 1, 16'h0068, 0, 4'b0000, 0, 4'b0100, 0, 0);
    add(4'b1011, 4'b1011, 1, 16'h0069, 0, 4'b0000, 0, 4'b0000, 0, 0);
    add(4'b1011, 4'b1011, 1, 16'h006A, 1, 4'b1000, 1, 4'b0000, 0, 3);
    add(4'b0011, 4'b0011, 1, 16'h006B, 0, 4'b0000, 0, 4'b1000, 0, 0);
    add(4'b0011, 4'b0011, 1, 16'h006C, 0, 4'b0000, 0, 4'b0000, 0, 0);
    add(4'b0011, 4'b0011, 1, 16'h006D, 1, 4'b0001, 1, 4'b0000, 0, 0);
    add(4'b0010, 4'b0010, 1, 16'h006E, 0, 4'b0000, 0, 4'b0001, 0, 0);
    add(4'b0010, 4'b0010, 1, 16'h006F, 0, 4'b0000, 0, 4'b0000, 0, 0);
    add(4'b0010, 4'b0010, 1, 16'h0070, 1, 4'b0010, 1, 4'b0000, 0, 1);
    add(4'b0000, 4'b0000, 1, 16'h0071, 0, 4'b0000, 0, 4'b0010, 0, 0);

    drv('0, '0, 1'b1);
    wr_address = '0;
    for (int j = 0; j < int'(NR); j++) begin
      req_data[j] = '0;
      req_ttl[j] = '0;
      req_byte_count[j] = '0;
    end

    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      drv(vecs[k].valid, vecs[k].last, vecs[k].ready);
      wr_address = vecs[k].addr;
      for (int j = 0; j < int'(NR); j++) begin
        req_data[j] = {4'(j), 28'(k)};
        req_ttl[j] = 8'(16 + j);
        req_byte_count[j] = 3'(j + 1);
      end
      #1;
      chk($sformatf("v%0d.wr_valid", k), 32'(wr_valid), 32'(vecs[k].exp_wv));
      chk($sformatf("v%0d.req_ready", k), 32'(req_ready), 32'(vecs[k].exp_rr));
      chk($sformatf("v%0d.wr_is_last", k), 32'(wr_is_last), 32'(vecs[k].exp_il));
      chk($sformatf("v%0d.done_valid", k), 32'(done_valid), 32'(vecs[k].exp_dv));
      if (vecs[k].exp_wv) begin
        chk($sformatf("v%0d.wr_data", k), wr_data, {4'(vecs[k].exp_src), 28'(k)});
        chk($sformatf("v%0d.wr_ttl", k), 32'(wr_ttl), 32'(16 + vecs[k].exp_src));
        chk($sformatf("v%0d.wr_byte_count", k), 32'(wr_byte_count),
            32'(vecs[k].exp_src + 1));
      end
      if (vecs[k].exp_dv != '0) begin
        chk($sformatf("v%0d.done_address", k), 32'(done_address),
            32'(vecs[k == 0 ? 0 : k - 1].addr));
        chk($sformatf("v%0d.done_trunc", k), 32'(done_trunc), 32'(vecs[k].exp_dt));
      end
    end

    // Stall: wr_ready 1,0,0,1 over a 2-word Req2 packet.
    @(negedge clk);
    drv(4'b0100, 4'b0000, 1'b1);
    req_data[2] = 32'hCAFE_0001;
    #1 chk("stall.idle_wr_valid", 32'(wr_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("stall.w1_wr_valid", 32'(wr_valid), 32'd1);
    chk("stall.w1_req_ready", 32'(req_ready), 32'b0100);
    chk("stall.w1_data", wr_data, 32'hCAFE_0001);
    @(negedge clk);
    drv(4'b0100, 4'b0100, 1'b0);
    req_data[2] = 32'hCAFE_0002;
    #1;
    chk("stall.s1_req_ready", 32'(req_ready), 32'd0);
    chk("stall.s1_wr_valid", 32'(wr_valid), 32'd1);
    chk("stall.s1_data", wr_data, 32'hCAFE_0002);
    @(negedge clk);
    #1;
    chk("stall.s2_req_ready", 32'(req_ready), 32'd0);
    chk("stall.s2_data", wr_data, 32'hCAFE_0002);
    @(negedge clk);
    wr_ready = 1'b1;
    #1;
    chk("stall.w2_req_ready", 32'(req_ready), 32'b0100);
    chk("stall.w2_is_last", 32'(wr_is_last), 32'd1);
    @(negedge clk);
    drv(4'b0000, 4'b0000, 1'b1);
    #1 chk("stall.done_valid", 32'(done_valid), 32'b0100);

    // TTL is held from the first word of the packet.
    @(negedge clk);
    drv(4'b1000, 4'b0000, 1'b1);
    req_ttl[3] = 8'd7;
    @(negedge clk);
    #1 chk("ttl.w1", 32'(wr_ttl), 32'd7);
    @(negedge clk);
    drv(4'b1000, 4'b1000, 1'b1);
    req_ttl[3] = 8'd3;
    #1;
    chk("ttl.w2", 32'(wr_ttl), 32'd7);
    chk("ttl.w2_is_last", 32'(wr_is_last), 32'd1);
    @(negedge clk);
    drv(4'b0000, 4'b0000, 1'b1);
    #1 chk("ttl.done_valid", 32'(done_valid), 32'b1000);

    // Truncation: Req0 sends 6 words with a 4-word limit.
    @(negedge clk);
    drv(4'b0001, 4'b0000, 1'b1);
    for (int w = 1; w <= 6; w++) begin
      @(negedge clk);
      req_data[0] = 32'(w);
      wr_address = (w == 4) ? 16'h0080 : 16'h0011;
      if (w == 6) req_is_last = 4'b0001;
      #1;
      chk($sformatf("trunc.w%0d_wr_valid", w), 32'(wr_valid), 32'(w <= 4));
      chk($sformatf("trunc.w%0d_req_ready", w), 32'(req_ready), 32'b0001);
      if (w <= 4) chk($sformatf("trunc.w%0d_is_last", w), 32'(wr_is_last), 32'(w == 4));
    end
    @(negedge clk);
    drv(4'b0000, 4'b0000, 1'b1);
    #1;
    chk("trunc.done_valid", 32'(done_valid), 32'b0001);
    chk("trunc.done_trunc", 32'(done_trunc), 32'd1);
    chk("trunc.done_address", 32'(done_address), 32'h0080);

    // Reset mid-packet: Req1 in burst, then Req0 must win after release.
    @(negedge clk);
    drv(4'b0010, 4'b0000, 1'b1);
    repeat (3) @(negedge clk);
    #1 chk("rst.pre_wr_valid", 32'(wr_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("rst.async");
    @(negedge clk);
    rst_n = 1'b1;
    drv(4'b0011, 4'b0011, 1'b1);
    @(negedge clk);
    #1;
    chk("rst.first_grant", 32'(req_ready), 32'b0001);
    chk("rst.first_wr_valid", 32'(wr_valid), 32'd1);
    @(negedge clk);
    drv(4'b0010, 4'b0010, 1'b1);
    #1 chk("rst.done_valid", 32'(done_valid), 32'b0001);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/payload_wr_arbiter.md
Name: payload_wr_arbiter

Overview:
- Shares the single payload-store write port (PayloadWrBus Slave side) between N_REQ packet sources.
- Grants are round-robin, packet-atomic: a grant is held from the first word through the isLast word.
- Returns the store-assigned address to the winning source on completion.
- Enforces a maximum packet length by truncating over-long packets and draining the excess words.
- Sits between the ingress packet parsers and the payload store.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- MAX_WORDS, 256, maximum words per packet; word MAX_WORDS is forced to isLast.
- REQ_W, $clog2(N_REQ), grant index width (derived; do not override).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- reqValid  input  [N_REQ]  requester i presents a word.
- reqReady  output  [N_REQ]  word of requester i consumed this cycle.
- reqIsLast  input  [N_REQ]  word is the final word of the packet.
- reqData  input  [N_REQ] x Data_t  payload word.
- reqTtl  input  [N_REQ] x Ttl_t  packet TTL; sampled on the first word only.
- reqByteCount  input  [N_REQ] x ByteCount_t  valid bytes in the word.
- doneValid  output  [N_REQ]  one-cycle pulse: packet of requester i is stored.
- doneAddress  output  Address_t  store address; valid while any doneValid is high.
- doneTrunc  output  1  qualifies doneValid: packet was truncated.
- wrValid  output  1  write strobe to store.
- wrReady  input  1  store accepts the word.
- wr  PayloadWrBus.Master  -  isLast, data, ttl, byteCount out; address in.

Behaviour:
- Reset values:
  - reqReady=0, doneValid=0, doneAddress=0, doneTrunc=0, wrValid=0, wr.isLast=0.
  - state=IDLE, lastGrant=N_REQ-1, so requester 0 has first priority.
  - wordCount=0.
- Reset asserted mid-burst aborts immediately; the store sees no further wrValid.
- Transfers:
  - Transfer = wrValid && wrReady.
  - Requester handshake: reqReady[i] high only for the granted i, and only in BURST or DRAIN.
- State IDLE:
  - If any reqValid is high, grant the first i searching upward from lastGrant+1 with wrap.
  - Register the grant into g, clear wordCount, go to BURST.
  - Arbitration latency is 1 cycle; no bus activity in IDLE.
- State BURST:
  - wrValid = reqValid[g].
  - Bus fields are muxed combinationally from requester g. ttl is held from the first word (registered at first transfer) for the whole packet.
  - reqReady[g] = wrReady.
  - On each transfer wordCount increments; the counter saturates and never wraps.
  - Transfer with reqIsLast[g]: capture wr.address into doneAddress, doneTrunc=0, go to DONE.
  - Transfer where wordCount==MAX_WORDS-1 and reqIsLast[g]=0: force wr.isLast=1 on that word, capture address, doneTrunc=1, go to DRAIN.
- State DRAIN:
  - wrValid=0; reqReady[g]=1.
  - Discard words until one with reqIsLast[g] is consumed, then go to DONE.
- State DONE:
  - doneValid[g]=1 for exactly one cycle; doneAddress/doneTrunc are stable.
  - lastGrant=g; go to IDLE.
  - Minimum inter-packet gap on the store bus is 2 cycles.
- Boundary conditions:
  - A requester dropping reqValid mid-packet keeps the grant; the bus idles (wrValid=0) with no timeout.
  - A single-word packet (isLast on the first word) is legal.
  - MAX_WORDS=1 forces every first word to isLast.
  - wrReady low holds the current word; requester data must stay stable until reqReady.
  - Other requesters' reqValid are ignored until IDLE.

Decomposition:
- Add to the PayloadBus package: ArbState_t enum {IDLE, BURST, DRAIN, DONE}; WordCount_t sized $clog2(MAX_WORDS+1).
- Sub-module rr_picker (combinational round-robin priority select: request vector + lastGrant -> grant index + anyReq). Reusable by other dispatch-side arbiters.

Test Plan:
- Req0 sends 3 words (isLast on word 3), wrReady=1, store address 0x40 -> wrValid for 3 consecutive cycles after 1 arbitration cycle; doneValid[0] pulse with doneAddress=0x40, doneTrunc=0.
- Req1 and Req2 both valid from reset, 2-word packets -> Req1 fully served first, then Req2; no interleaving; next contest with Req1 again wins Req2... order rotates 1,2,then 3/0 per lastGrant.
- wrReady toggles 1,0,0,1 during a 2-word packet -> reqReady mirrors wrReady; words transfer only on high cycles; data unchanged on the bus while stalled.
- MAX_WORDS=4, Req3 sends 6 words -> 4 words to store, 4th has wr.isLast=1; words 5-6 consumed with wrValid=0; doneTrunc=1 with doneValid[3].
- rst_n pulsed low after word 2 of a 5-word packet -> all outputs 0 asynchronously; after release Req0 wins arbitration first.
- TTL 7 on word 1, changing to 3 on word 2 -> wr.ttl stays 7 for both words.
